// File: rtl/bin_to_bcd_conv.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_conv
//
// Converts a BIN_W-bit unsigned or two's-complement value to DIGITS packed BCD
// digits using shift-and-add-3 (double dabble), one input bit per clock. It
// also reports the sign and the number of significant digits. When BLANK_LZ=1,
// leading-zero digit positions are replaced by 4'hF so that a character
// formatter can skip them directly.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     in_data/in_signed valid
//   in_ready     converter idle, accepts input
//   in_data      binary value (BIN_W bits)
//   in_signed    1: in_data is two's complement
//   out_valid    result valid
//   out_ready    consumer accepts result
//   out_bcd      digit k at [4k+3:4k], k=0 least significant
//   out_neg      value was negative
//   out_ndigits  significant digits, 1..DIGITS (zero reports 1)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE, and
// out_bcd/out_neg/out_ndigits are held stable from the rise of out_valid until
// the edge that completes the output transfer. out_valid never drops without a
// transfer or reset.
//
// Latency: accept on edge E0, BIN_W shift edges, one finish edge; out_valid is
// high BIN_W+1 cycles after acceptance. Issue interval is BIN_W+3 cycles.
// -----------------------------------------------------------------------------
module bin_to_bcd_conv #(
  parameter int unsigned BIN_W    = 32,
  parameter int unsigned DIGITS   = 10,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIN_W-1:0]             in_data,
  input  logic                         in_signed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          out_bcd,
  output logic                         out_neg,
  output logic [$clog2(DIGITS+1)-1:0]  out_ndigits
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned NDW   = $clog2(DIGITS + 1);
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

  // Parameter legality is checked at elaboration time.
  if (BIN_W < 2 || BIN_W > 64) begin : g_bad_bin_w
    $error("bin_to_bcd_conv: BIN_W must be in 2..64");
  end
  if (DIGITS < ((BIN_W * 1233) >> 12) + 1) begin : g_bad_digits
    $error("bin_to_bcd_conv: DIGITS too small for BIN_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   acc_q;
  logic [BIN_W-1:0]   shreg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic [ACC_W-1:0]   out_bcd_q;
  logic               out_neg_q;
  logic [NDW-1:0]     out_ndigits_q;

  logic               neg_d;
  logic [BIN_W-1:0]   mag_d;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_d;
  logic [BIN_W-1:0]   shreg_d;
  logic [NDW-1:0]     ndig_d;
  logic [ACC_W-1:0]   bcd_d;

  // Magnitude of the incoming value. The most negative value negates to
  // itself, which read as unsigned is exactly 2^(BIN_W-1).
  always_comb begin
    neg_d = in_signed & in_data[BIN_W-1];
    mag_d = neg_d ? (~in_data + BIN_W'(1)) : in_data;
  end

  // One double-dabble iteration: add 3 to every digit >= 5, then shift the
  // shift register MSB into digit 0.
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    acc_d   = (acc_adj << 1) | ACC_W'(shreg_q[BIN_W-1]);
    shreg_d = shreg_q << 1;
  end

  // Significant-digit count and optional leading-zero blanking. Digit 0 is
  // always significant, so a zero value reports one digit.
  always_comb begin
    ndig_d = NDW'(1);
    for (int k = 1; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] != 4'd0) begin
        ndig_d = NDW'(k + 1);
      end
    end
    bcd_d = acc_q;
    if (BLANK_LZ) begin
      for (int k = 1; k < DIGITS; k++) begin
        if (k >= int'(ndig_d)) begin
          bcd_d[4*k +: 4] = 4'hF;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      acc_q         <= '0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      neg_q         <= 1'b0;
      out_bcd_q     <= '0;
      out_neg_q     <= 1'b0;
      out_ndigits_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            neg_q      <= neg_d;
            acc_q      <= '0;
            shreg_q    <= mag_d;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q   <= acc_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          out_bcd_q     <= bcd_d;
          out_neg_q     <= neg_q;
          out_ndigits_q <= ndig_d;
          out_valid_q   <= 1'b1;
          state_q       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_bcd     = out_bcd_q;
  assign out_neg     = out_neg_q;
  assign out_ndigits = out_ndigits_q;

endmodule

// File: doc/bin_to_bcd_conv.md
# bin_to_bcd_conv

Parametrised, handshaked binary-to-BCD converter for the UART/AHB-Lite console path. Converts a BIN_W-bit unsigned or two's-complement value to DIGITS packed BCD digits with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It also reports sign and significant-digit count, and optionally blanks leading zeros so the UART formatter can print without post-processing. Valid/ready on both sides allows it to sit directly between a register-read stage and the character serialiser.

## Interface
- BIN_W, 32, input width in bits (2..64)
- DIGITS, 10, BCD digits produced; elaboration error if DIGITS < ((BIN_W*1233)>>12)+1
- BLANK_LZ, 0, 1: leading-zero digit positions output as 4'hF instead of 4'h0
- clk  input  1  clock; all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_signed valid
- in_ready  output  1  converter idle, accepts input
- in_data  input  BIN_W  binary value
- in_signed  input  1  1: in_data is two's complement
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_bcd  output  4*DIGITS  digit k at [4k+3:4k], k=0 least significant
- out_neg  output  1  value was negative (only possible when in_signed=1)
- out_ndigits  output  $clog2(DIGITS+1)  significant digits, 1..DIGITS (0 reports 1)

## Operation
- States: IDLE, SHIFT, FIN, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready: mag = (in_signed && in_data[BIN_W-1]) ? -in_data : in_data, taken as BIN_W-bit unsigned. -2^(BIN_W-1) gives magnitude 2^(BIN_W-1), no overflow. Latch neg flag, clear BCD accumulator, load shift register with mag, clear bit counter, go to SHIFT.
- SHIFT: one iteration per cycle, exactly BIN_W cycles.
  - Every accumulator digit >= 5 gets +3.
  - Then {acc, shreg} shifts left by 1, so the MSB of shreg enters acc digit 0.
  - Add-3 and shift are combined in one registered update.
  - After the BIN_W-th iteration, go to FIN.
- FIN: one cycle. Compute ndigits = (index of most significant nonzero digit)+1, or 1 if all digits are zero. Apply blanking when BLANK_LZ=1: digits at positions >= ndigits become 4'hF, and digit 0 is never blanked. Register out_bcd, out_neg, out_ndigits. Go to DONE.
- DONE: out_valid=1. All outputs are held stable until out_valid&&out_ready. Then go to IDLE.
- in_ready is 0 in SHIFT, FIN and DONE. in_valid there is ignored and does not need to be held off by the source beyond the handshake rule.
- out_neg=0 whenever in_signed=0 or the value is non-negative. Negative zero cannot occur.

## Timing
- Reset (rst_n low, asynchronous, any state, including mid-conversion): state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_neg=0, out_ndigits=0, counter/accumulator/shreg=0. Any partial result is discarded. First acceptance is possible on the first rising edge after rst_n deasserts.
- Accept on edge E0. SHIFT occupies edges E1..E_BIN_W, FIN updates at edge E_BIN_W+1, and out_valid is high after that edge. Latency is BIN_W+1 cycles from acceptance to out_valid (33 for BIN_W=32).
- Result handshake on edge Ex puts the block in IDLE after Ex. Earliest next acceptance is edge Ex+1. Minimum issue interval is BIN_W+3 cycles with out_ready tied high.
- out_ready high before out_valid has no effect. out_valid never drops without a handshake or reset.

## Test plan
- BIN_W=32, DIGITS=10, BLANK_LZ=0, unsigned 32'hFFFF_FFFF -> out_bcd=40'h42_9496_7295, out_ndigits=10, out_neg=0, out_valid exactly 33 cycles after accept.
- Signed 32'h8000_0000 -> out_bcd=40'h21_4748_3648, out_neg=1, ndigits=10. Signed 32'hFFFF_FFFF -> out_bcd=1, out_neg=1, ndigits=1.
- Zero and small values, BLANK_LZ=1: 0 -> out_bcd=40'hFF_FFFF_FFF0, ndigits=1. Value 1000 -> 40'hFF_FFFF_1000, ndigits=4.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> outputs constant, in_ready=0 throughout, and in_valid pulses with new data are ignored. Release -> one handshake, in_ready=1 next cycle.
- Reset mid-SHIFT (rst_n low at cycle 10 of a conversion, asynchronous to clk) -> outputs go to reset values immediately. A following conversion of 12345 gives 40'h00_0001_2345 with normal latency.
- Parameter sweep BIN_W=8/DIGITS=3 and BIN_W=4/DIGITS=2: exhaustive unsigned and signed inputs against a reference model. Latency is BIN_W+1 cycles. Back-to-back interval is BIN_W+3 cycles with out_ready=1.
